muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS pipelined datapath. It sits beside the EX-stage ALU. It accepts one mult/multu/div/divu per start pulse, runs a 32-step shift-add or restoring-divide loop, and writes HI/LO on completion. It drives `Stall` so the hazard logic holds IF/ID/EX while an operation is in flight. It also serves mthi/mtlo writes and exposes HI/LO continuously for mfhi/mflo forwarding.

## Interface
- No parameters; width fixed at 32.
- `Clk` in 1: single clock; all state changes on rising edge.
- `Reset` in 1: synchronous, active-high.
- `Start` in 1: launch operation; sampled only in IDLE.
- `Op` in 2: 00 multu, 01 mult, 10 divu, 11 div.
- `A` in 32: multiplicand / dividend (rs).
- `B` in 32: multiplier / divisor (rt).
- `HiWrite` in 1: mthi write enable.
- `LoWrite` in 1: mtlo write enable.
- `WriteData` in 32: mthi/mtlo data.
- `Hi` out 32: HI register.
- `Lo` out 32: LO register.
- `Busy` out 1: operation in flight.
- `Stall` out 1: equals `Busy`; to hazard unit.
- `Done` out 1: one-cycle pulse when HI/LO take a new result.

## Operation
- States: IDLE, RUN, FIX.
- IDLE + `Start`: latch `Op`. Latch |A|, |B| for signed ops, raw values for unsigned. Record sign flags. Clear the 64-bit accumulator/remainder and the 6-bit step counter. Go to RUN.
- RUN: one iteration per cycle, 32 iterations.
  - Multiply: shift-add on magnitudes.
  - Divide: restoring, one quotient bit per step.
  - After the 32nd iteration, go to FIX.
- FIX, multiply: negate the 64-bit product if sign(A) xor sign(B) (signed only). HI = product[63:32], LO = product[31:0].
- FIX, divide: LO = quotient, negated if signs differ. HI = remainder, negated if A negative (remainder takes dividend sign). Signed only for both negations.
- FIX: assert `Done`, return to IDLE.
- Divide by zero, no special casing; result follows from the algorithm.
  - divu: LO = 0xFFFFFFFF, HI = A.
  - div: LO = 0xFFFFFFFF if A ≥ 0, else 0x00000001; HI = A.
- div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap.
- mthi/mtlo:
  - In IDLE, with `Start` low, `HiWrite`/`LoWrite` load `WriteData` into HI/LO. Both may be asserted in the same cycle.
  - In IDLE, with `Start` high, `Start` wins and the writes are dropped.
  - In RUN/FIX, writes are ignored. The pipeline is stalled, so none are legal there.
- `Start` while Busy is ignored. No queueing.
- HI/LO hold their values between operations. They change only in FIX, on mthi/mtlo, or on reset.

## Timing
- Edge 0 samples `Start` in IDLE. `Busy`/`Stall` go high after edge 0.
- Edges 1–32 are iterations. Edge 32 enters FIX.
- Edge 33 writes HI/LO and returns to IDLE. After edge 33, `Done` = 1 for exactly one cycle and `Busy` = 0.
- Total latency: 33 cycles from start-sampling edge to result visible; 34th cycle is result-valid.
- A new `Start` may be sampled on edge 33+1, the cycle `Done` is high. Back-to-back operations are legal.
- mthi/mtlo writes become visible on `Hi`/`Lo` the cycle after the write edge.
- Reset values:
  - State IDLE; counter 0.
  - `Hi`, `Lo` = 0.
  - `Busy`, `Stall`, `Done` = 0.
- Reset asserted mid-operation aborts the operation. HI/LO are not updated with any partial result; they go to 0.

## Configuration
- `MULDIV_DIV_EN`
  - Defined: full behaviour above.
  - Undefined: divider logic is not compiled. Op 10/11 with `Start` does not enter RUN. It completes on the sampling edge: `Done` pulses the next cycle, HI/LO are unchanged, and `Busy` never asserts. Multiply is unaffected.

## Test plan
- multu A=0xFFFFFFFF, B=0xFFFFFFFF → `Done` in the 34th cycle after the start edge; Hi=0xFFFFFFFE, Lo=0x00000001; `Stall` high for exactly 33 cycles.
- mult A=0xFFFFFFFD (−3), B=7 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; then immediately div A=0xFFFFFFF9 (−7), B=2 started in the `Done` cycle → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- divu A=0x12345678, B=0 → Lo=0xFFFFFFFF, Hi=0x12345678.
  - div A=0x80000000, B=0xFFFFFFFF → Lo=0x80000000, Hi=0.
- mthi 0xAAAA0000 and mtlo 0x0000BBBB in the same idle cycle → Hi/Lo updated next cycle.
  - `HiWrite` with `Start` high in the same cycle → write dropped; operation result lands.
  - `HiWrite` during RUN → ignored.
- Reset at iteration 10 of multu 5×6 → next cycle: Busy=0, Hi=Lo=0, no `Done`.
  - `Start` pulses while Busy are ignored.
- Build without `MULDIV_DIV_EN`: divu 10/3 → `Done` next cycle, Busy never high, Hi/Lo unchanged; multu 10×3 → Lo=30 after 33 cycles.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative 32-bit multiply/divide unit that owns HI/LO.
// One mult/multu/div/divu per Start pulse, 32 iterations, result in FIX.
// Stall mirrors Busy so the hazard unit can freeze IF/ID/EX meanwhile.
// Build option: define MULDIV_DIV_EN to compile the restoring divider; without
// it, divide ops complete immediately with a Done pulse and HI/LO unchanged.
module muldiv_sequencer (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        HiWrite,
   input  logic        LoWrite,
   input  logic [31:0] WriteData,
   output logic [31:0] Hi,
   output logic [31:0] Lo,
   output logic        Busy,
   output logic        Stall,
   output logic        Done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t      state;
   logic [5:0]  count;
   logic [63:0] acc;      // product, or {remainder, quotient}
   logic [31:0] ma;       // |multiplicand| or |dividend| (dividend shifts out MSB first)
   logic [31:0] mb;       // |multiplier| (shifts out LSB first) or |divisor|
   logic        neg_q;    // negate product / quotient at FIX
`ifdef MULDIV_DIV_EN
   logic        is_div;
   logic        neg_r;    // remainder takes the dividend's sign
`endif

   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic        op_ok;
   logic [32:0] mul_sum;
   logic [63:0] fix_prod;
`ifdef MULDIV_DIV_EN
   logic [32:0] div_trial;
   logic [32:0] div_diff;
   logic        div_ge;
   logic [31:0] div_rem;
   logic [31:0] fix_quo;
   logic [31:0] fix_rem;
`endif

   assign Stall = Busy;

   // Operand conditioning, one iteration step of each algorithm, and sign fix-up.
   always_comb begin
      // NOTE: every signal driven here gets a value on every path first, so no latch is inferred.
      abs_a    = (Op[0] && A[31]) ? -A : A;
      abs_b    = (Op[0] && B[31]) ? -B : B;
`ifdef MULDIV_DIV_EN
      op_ok    = 1'b1;
`else
      op_ok    = ~Op[1];
`endif
      // Right-shifting shift-add: add into the upper half, shift the pair right.
      mul_sum  = {1'b0, acc[63:32]} + (mb[0] ? {1'b0, ma} : 33'd0);
      fix_prod = neg_q ? -acc : acc;
`ifdef MULDIV_DIV_EN
      // Restoring step: bring in the next dividend bit, subtract if it fits.
      div_trial = {acc[63:32], ma[31]};
      div_diff  = div_trial - {1'b0, mb};
      div_ge    = (div_trial >= {1'b0, mb});
      div_rem   = div_ge ? div_diff[31:0] : div_trial[31:0];
      fix_quo   = neg_q ? -acc[31:0]  : acc[31:0];
      fix_rem   = neg_r ? -acc[63:32] : acc[63:32];
`endif
   end

   // Sequencer FSM with registered Busy/Done and the HI/LO register pair.
   always_ff @(posedge Clk) begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      if (Reset) begin
         state  <= S_IDLE;
         count  <= '0;
         acc    <= '0;
         ma     <= '0;
         mb     <= '0;
         neg_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
         is_div <= 1'b0;
         neg_r  <= 1'b0;
`endif
         Hi     <= '0;
         Lo     <= '0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Start && op_ok) begin
                  ma     <= abs_a;
                  mb     <= abs_b;
                  acc    <= '0;
                  count  <= '0;
                  neg_q  <= Op[0] & (A[31] ^ B[31]);
`ifdef MULDIV_DIV_EN
                  is_div <= Op[1];
                  neg_r  <= Op[0] & A[31];
`endif
                  Busy   <= 1'b1;
                  state  <= S_RUN;
               end else if (Start) begin
                  // Divide requested but not built: acknowledge without touching HI/LO.
                  Done <= 1'b1;
               end else begin
                  if (HiWrite) Hi <= WriteData;
                  if (LoWrite) Lo <= WriteData;
               end
            end
            S_RUN: begin
`ifdef MULDIV_DIV_EN
               if (is_div) begin
                  acc <= {div_rem, acc[30:0], div_ge};
                  ma  <= {ma[30:0], 1'b0};
               end else begin
                  acc <= {mul_sum, acc[31:1]};
                  mb  <= {1'b0, mb[31:1]};
               end
`else
               acc <= {mul_sum, acc[31:1]};
               mb  <= {1'b0, mb[31:1]};
`endif
               count <= count + 6'd1;
               if (count == 6'd31) state <= S_FIX;
            end
            S_FIX: begin
`ifdef MULDIV_DIV_EN
               if (is_div) begin
                  Hi <= fix_rem;
                  Lo <= fix_quo;
               end else begin
                  Hi <= fix_prod[63:32];
                  Lo <= fix_prod[31:0];
               end
`else
               Hi <= fix_prod[63:32];
               Lo <= fix_prod[31:0];
`endif
               Done  <= 1'b1;
               Busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: scoreboard of expected {Hi,Lo}
// pushed at start, popped on every Done pulse. Divide expectations follow the
// MULDIV_DIV_EN build option.
module tb_muldiv_sequencer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        HiWrite;
   logic        LoWrite;
   logic [31:0] WriteData;
   logic [31:0] Hi;
   logic [31:0] Lo;
   logic        Busy;
   logic        Stall;
   logic        Done;

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [63:0] sb_q[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [63:0] mon_exp;

   always #5 Clk = ~Clk;

   muldiv_sequencer dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
      .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
      .Hi(Hi), .Lo(Lo), .Busy(Busy), .Stall(Stall), .Done(Done)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference result {hi, lo}; cur is returned when divide is not built.
   function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
      logic signed [31:0] sa, sb, q, r;
      ref_op = cur;
      case (op)
         2'b00: ref_op = {32'd0, a} * {32'd0, b};
         2'b01: ref_op = {{32{a[31]}}, a} * {{32{b[31]}}, b};
`ifdef MULDIV_DIV_EN
         2'b10: ref_op = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
         2'b11: begin
            if (b == 0)
               ref_op = {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
               ref_op = {32'h0, 32'h80000000};
            else begin
               sa = a; sb = b; q = sa / sb; r = sa % sb;
               ref_op = {r, q};
            end
         end
`endif
         default: ref_op = cur;
      endcase
   endfunction

   // Scoreboard: every Done pulse must match the oldest outstanding expectation.
   always @(negedge Clk) begin
      if (!Reset && Done) begin
         if (sb_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
         else begin
            mon_exp = sb_q.pop_front();
            check("result", {Hi, Lo}, mon_exp);
         end
      end
   end

   // Launch one op at the current negedge and wait for its Done (bounded).
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hw, input bit disturb);
      logic [63:0] exp, old;
      int k, nb, exp_lat, exp_busy;
      bit short_op;
      old = {m_hi, m_lo};
      exp = ref_op(op, a, b, old);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
`ifdef MULDIV_DIV_EN
      short_op = 1'b0;
`else
      short_op = op[1];
`endif
      exp_lat  = short_op ? 1 : 34;
      exp_busy = short_op ? 0 : 33;
      sb_q.push_back(exp);
      Start = 1'b1; Op = op; A = a; B = b;
      HiWrite = hw; WriteData = 32'hDEADBEEF;
      @(negedge Clk);
      Start = 1'b0; HiWrite = 1'b0;
      if (hw && !short_op) check("hiwrite_vs_start", {32'd0, Hi}, {32'd0, old[63:32]});
      nb = 0;
      for (k = 1; k <= 40; k++) begin
         if (Stall) nb++;
         if (Done) break;
         if (disturb && k == 5) begin
            HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'h13579BDF;
            Start = 1'b1; Op = 2'b01; A = $urandom; B = $urandom;
         end
         if (disturb && k == 6) begin
            check("hilo_hold_in_run", {Hi, Lo}, old);
            HiWrite = 1'b0; LoWrite = 1'b0; Start = 1'b0;
         end
         if (disturb && k == 20) Start = 1'b1;
         if (disturb && k == 21) Start = 1'b0;
         @(negedge Clk);
      end
      check("latency", k, exp_lat);
      check("stall_cycles", nb, exp_busy);
   endtask

   task automatic write_hilo(input bit hw, input bit lw, input logic [31:0] data);
      HiWrite = hw; LoWrite = lw; WriteData = data;
      if (hw) m_hi = data;
      if (lw) m_lo = data;
      @(negedge Clk);
      HiWrite = 1'b0; LoWrite = 1'b0;
      check("mthi_mtlo", {Hi, Lo}, {m_hi, m_lo});
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd;
      Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
      HiWrite = 1'b0; LoWrite = 1'b0; WriteData = '0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      check("reset_hi", {32'd0, Hi}, 64'd0);
      check("reset_lo", {32'd0, Lo}, 64'd0);
      check("reset_busy", {63'd0, Busy}, 64'd0);
      check("reset_stall", {63'd0, Stall}, 64'd0);
      check("reset_done", {63'd0, Done}, 64'd0);

      // Multiply corner, then back-to-back mult -> div started in the Done cycle.
      run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      run_op(2'b01, 32'hFFFFFFFD, 32'd7,        1'b0, 1'b0);
      run_op(2'b11, 32'hFFFFFFF9, 32'd2,        1'b0, 1'b0);
      // Divide boundaries: by zero, overflow case, negative by zero.
      run_op(2'b10, 32'h12345678, 32'd0,        1'b0, 1'b0);
      run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
      run_op(2'b11, 32'h80000000, 32'd0,        1'b0, 1'b0);
      repeat (2) @(negedge Clk);

      // mthi / mtlo, separately and together.
      write_hilo(1'b1, 1'b0, 32'hAAAA0000);
      write_hilo(1'b0, 1'b1, 32'h0000BBBB);
      write_hilo(1'b1, 1'b1, 32'h5A5A5A5A);

      // Start beats HiWrite; writes and Start pulses during RUN are ignored.
      run_op(2'b00, 32'd2, 32'd3, 1'b1, 1'b0);
      run_op(2'b00, 32'd1234, 32'd5678, 1'b0, 1'b1);
      repeat (3) @(negedge Clk);

      // Reset at iteration 10 of multu 5x6 aborts without a result.
      write_hilo(1'b1, 1'b1, 32'h0F0F0F0F);
      Start = 1'b1; Op = 2'b00; A = 32'd5; B = 32'd6;
      @(negedge Clk);
      Start = 1'b0;
      repeat (9) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      m_hi = '0; m_lo = '0;
      check("abort_busy", {63'd0, Busy}, 64'd0);
      check("abort_hilo", {Hi, Lo}, 64'd0);
      check("abort_done", {63'd0, Done}, 64'd0);
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (Done) nd++;
      end
      check("abort_no_done", nd, 0);

      // divu 10/3 and multu 10x3 (divu completes at once when divide is not built).
      run_op(2'b10, 32'd10, 32'd3, 1'b0, 1'b0);
      run_op(2'b00, 32'd10, 32'd3, 1'b0, 1'b0);

      for (int i = 0; i < 8; i++)
         run_op(2'($urandom_range(0, 3)), $urandom,
                (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom, 1'b0, 1'b0);

      repeat (5) @(negedge Clk);
      check("scoreboard_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
